// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, memory size and
// access-size codes.
package mem_pkg;

  localparam int MEM_BYTES = 1024;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RMW_RD   = 3'd3,
    ST_RMW_WAIT = 3'd4,
    ST_WR       = 3'd5,
    ST_RESP     = 3'd6
  } mau_state_e;

  // Out of range, or a halfword on an odd address.
  function automatic logic req_is_bad(input logic [15:0] addr, input logic size);
    return (addr >= 16'(MEM_BYTES)) || ((size == SIZE_HALF) && addr[0]);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for a big-endian halfword memory: load formatting and
// byte-store merge. Purely combinational.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [15:0] rd_data,
  input  logic        addr_lsb,
  input  logic        size,
  input  logic        sign_ext,
  input  logic [7:0]  wr_byte,
  output logic [15:0] load_data,
  output logic [15:0] merge_data
);

  logic [7:0] sel_byte;

  always_comb begin
    // Even address lives in the upper byte of the halfword.
    sel_byte = addr_lsb ? rd_data[7:0] : rd_data[15:8];
    if (size == SIZE_HALF) begin
      load_data = rd_data;
    end else begin
      load_data = {{8{sign_ext & sel_byte[7]}}, sel_byte};
    end
    merge_data = addr_lsb ? {rd_data[15:8], wr_byte} : {wr_byte, rd_data[7:0]};
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a 1024-byte big-endian data memory with a
// one-cycle registered read; byte stores are done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester must hold its request stable until then. Each accepted
  // request yields exactly one single-cycle resp_valid pulse.

  mau_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        size_q, size_d;
  logic        signed_q, signed_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_read, mem_write;
  logic        accept;
  logic        bad_req;
  logic [15:0] load_data;
  logic [15:0] merge_data;

  mem_byte_lane u_lane (
    .rd_data    (mem_read_data),
    .addr_lsb   (addr_q[0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .wr_byte    (wdata_q[7:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign bad_req   = req_is_bad(req_addr, req_size);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    signed_d  = signed_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          signed_d = req_signed;
          err_d    = bad_req;
          if (bad_req) begin
            rdata_d = 16'h0000;
            state_d = ST_RESP;
          end else if (req_write) begin
            state_d = (req_size == SIZE_HALF) ? ST_WR : ST_RMW_RD;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read = 1'b1;
        state_d  = ST_RMW_WAIT;
      end
      ST_RMW_WAIT: begin
        // Old halfword is on mem_read_data now; the merged word becomes the write data.
        wdata_d = merge_data;
        state_d = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        rdata_d   = 16'h0000;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      size_q   <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes are gated by rst so an aborted access never touches memory.
  assign memRead        = mem_read & ~rst;
  assign memWrite       = mem_write & ~rst;
  assign mem_addr       = {addr_q[15:1], 1'b0};
  assign mem_write_data = wdata_q;
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_err       = resp_valid & err_q;
  assign resp_rdata     = rdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural big-endian memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        memRead;
  logic        memWrite;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .memRead        (memRead),
    .memWrite       (memWrite),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [MEM_BYTES];
  logic       mem_init_done = 1'b0;
  int         mem_wr_cnt = 0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= (i % 2 == 1) ? 8'(i >> 1) : 8'h00;
      end
      mem_init_done <= 1'b1;
    end else begin
      if (memWrite) begin
        mem[{mem_addr[9:1], 1'b0}] <= mem_write_data[15:8];
        mem[{mem_addr[9:1], 1'b1}] <= mem_write_data[7:0];
        mem_wr_cnt <= mem_wr_cnt + 1;
      end
      if (memRead) begin
        mem_read_data <= {mem[{mem_addr[9:1], 1'b0}], mem[{mem_addr[9:1], 1'b1}]};
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        sz;
    logic        sg;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [15:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic sz, input logic sg,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr,
                              input logic [15:0] exp_wdata);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int lat, rd_n, wr_n, both_n;
    logic [15:0] got_rdata, got_wdata, exp_rd_val;
    logic got_err;
    lat = 0; rd_n = 0; wr_n = 0; both_n = 0;
    got_rdata = 16'h0; got_wdata = 16'h0; got_err = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sg;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      if (memRead) rd_n++;
      if (memWrite) begin
        wr_n++;
        got_wdata = mem_write_data;
      end
      if (memRead && memWrite) both_n++;
      if (resp_valid) begin
        lat = c;
        got_rdata = resp_rdata;
        got_err = resp_err;
        break;
      end
    end
    exp_rd_val = exp_q.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
    check({tag, "_rdata"}, 32'(got_rdata), 32'(exp_rd_val));
    check({tag, "_memread_cycles"}, 32'(rd_n), 32'(v.exp_rd));
    check({tag, "_memwrite_cycles"}, 32'(wr_n), 32'(v.exp_wr));
    check({tag, "_rw_overlap"}, 32'(both_n), 32'd0);
    if (v.exp_wr != 0) check({tag, "_wdata"}, 32'(got_wdata), 32'(v.exp_wdata));
    @(negedge clk);
    check({tag, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata_hold"}, 32'(resp_rdata), 32'(exp_rd_val));
  endtask

  // ---------------- test ----------------
  vec_t vecs[18];
  int   wr_before;
  int   stray_resp;

  initial begin
    vecs[0]  = mk(0, 1, 0, 16'h0010, 16'h0000, 16'h0008, 0, 3, 1, 0, 16'h0000); // lh
    vecs[1]  = mk(1, 1, 0, 16'h0020, 16'h80AA, 16'h0000, 0, 2, 0, 1, 16'h80AA); // sh
    vecs[2]  = mk(0, 0, 1, 16'h0020, 16'h0000, 16'hFF80, 0, 3, 1, 0, 16'h0000); // lb signed
    vecs[3]  = mk(0, 0, 0, 16'h0021, 16'h0000, 16'h00AA, 0, 3, 1, 0, 16'h0000); // lbu odd
    vecs[4]  = mk(1, 0, 0, 16'h0031, 16'h005A, 16'h0000, 0, 4, 1, 1, 16'h005A); // sb odd
    vecs[5]  = mk(0, 1, 0, 16'h0030, 16'h0000, 16'h005A, 0, 3, 1, 0, 16'h0000); // lh
    vecs[6]  = mk(0, 1, 0, 16'h0013, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000); // misaligned
    vecs[7]  = mk(0, 0, 0, 16'h0400, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000); // out of range
    vecs[8]  = mk(0, 0, 1, 16'h0031, 16'h0000, 16'h005A, 0, 3, 1, 0, 16'h0000); // lb signed positive
    vecs[9]  = mk(1, 0, 0, 16'h0050, 16'hABC3, 16'h0000, 0, 4, 1, 1, 16'hC328); // sb even
    vecs[10] = mk(0, 1, 0, 16'h0050, 16'h0000, 16'hC328, 0, 3, 1, 0, 16'h0000);
    vecs[11] = mk(0, 0, 0, 16'h0050, 16'h0000, 16'h00C3, 0, 3, 1, 0, 16'h0000);
    vecs[12] = mk(0, 0, 1, 16'h0051, 16'h0000, 16'h0028, 0, 3, 1, 0, 16'h0000);
    vecs[13] = mk(0, 1, 0, 16'h03FE, 16'h0000, 16'h00FF, 0, 3, 1, 0, 16'h0000); // top halfword
    vecs[14] = mk(0, 0, 1, 16'h03FF, 16'h0000, 16'hFFFF, 0, 3, 1, 0, 16'h0000); // last byte signed
    vecs[15] = mk(1, 1, 0, 16'h03FF, 16'h1234, 16'h0000, 1, 1, 0, 0, 16'h0000); // sh misaligned
    vecs[16] = mk(0, 1, 0, 16'hFFFE, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000); // far out of range
    vecs[17] = mk(1, 0, 0, 16'h03FF, 16'h0077, 16'h0000, 0, 4, 1, 1, 16'h0077); // sb last byte

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
    check("rst_strobes", 32'({memRead, memWrite}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during the WR cycle of a byte store must abort it without a write.
    @(negedge clk);
    wr_before = mem_wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_BYTE; req_signed = 1'b0;
    req_addr = 16'h0041; req_wdata = 16'h00FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_in_wr", 32'(dbg_state), 32'(ST_WR));
    rst = 1'b1;
    @(negedge clk);
    check("abort_memwrite_gated", 32'(memWrite), 32'd0);
    check("abort_memread_gated", 32'(memRead), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_mem_wdata", 32'(mem_write_data), 32'd0);
    check("abort_rdata", 32'(resp_rdata), 32'd0);
    stray_resp = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) stray_resp++;
      @(negedge clk);
    end
    check("abort_no_resp", 32'(stray_resp), 32'd0);
    check("abort_no_write", 32'(mem_wr_cnt - wr_before), 32'd0);
    run_vec(mk(0, 1, 0, 16'h0040, 16'h0000, 16'h0020, 0, 3, 1, 0, 16'h0000), "post_abort_lh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
